inmp441_mic_i2s_transmitter: RTL and testbench

//  I2S slave transmitter that emulates an INMP441 MEMS microphone: the I2S master (the board's mic receiver) drives SCK and WS; this block shifts
//  24-bit two's-complement samples out on SD, MSB first, in the channel slot selected by LR. It is used for loopback boards and self-checking

---
 rtl/i2s_pkg.sv | 9 +
 rtl/i2s_edge_sync.sv | 30 +++
 rtl/inmp441_mic_i2s_transmitter.sv | 153 +++++++++++++++
 tb/tb_inmp441_mic_i2s_transmitter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S microphone-emulation transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} i2s_tx_state_t;

  localparam int I2S_SAMPLE_W  = 24;
  localparam int I2S_SLOT_BITS = 32;

endpackage

// File: rtl/i2s_edge_sync.sv
// Synchronizes an asynchronous I2S pin into clk and flags its rising/falling edges.
module i2s_edge_sync
  import i2s_pkg::*;
#(
  parameter int sync_stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  // Bits [sync_stages-1:0] are the synchronizer; the top bit keeps the previous synchronized value.
  logic [sync_stages:0] chain_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[sync_stages-1:0], pin};
    end
  end

  assign level = chain_reg[sync_stages-1];
  assign rise  = chain_reg[sync_stages-1] & ~chain_reg[sync_stages];
  assign fall  = ~chain_reg[sync_stages-1] & chain_reg[sync_stages];

endmodule

// File: rtl/inmp441_mic_i2s_transmitter.sv
// I2S slave transmitter emulating an INMP441: shifts buffered 24-bit samples out on sd in the lr slot.
// sd_oe is the pad enable; the board top wraps the pin as sd_oe ? sd : 'z.
module inmp441_mic_i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int w_sample    = I2S_SAMPLE_W,
  parameter int slot_bits   = I2S_SLOT_BITS,
  parameter int sync_stages = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [w_sample-1:0] sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                lr,
  input  logic                sck,
  input  logic                ws,
  output logic                sd,
  output logic                sd_oe,
  output logic                underrun,
  output logic                frame_err
);

  localparam int cnt_w = $clog2(slot_bits + 1);

  logic sck_level_unused, sck_rise, sck_fall;
  logic ws_level, ws_rise_unused, ws_fall_unused;

  i2s_edge_sync #(.sync_stages(sync_stages)) u_sck_sync (
    .clk(clk), .rst(rst), .pin(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  i2s_edge_sync #(.sync_stages(sync_stages)) u_ws_sync (
    .clk(clk), .rst(rst), .pin(ws),
    .level(ws_level), .rise(ws_rise_unused), .fall(ws_fall_unused)
  );

  i2s_tx_state_t       state_reg, state_next;
  logic [cnt_w-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [w_sample-1:0] shift_reg, shift_next;
  logic [w_sample-1:0] buf_reg, buf_next;
  logic                buf_full_reg, buf_full_next;
  logic                sd_reg, sd_next;
  logic                oe_reg, oe_next;
  logic                underrun_reg, underrun_next;
  logic                frame_err_reg, frame_err_next;
  logic                ws_cur_reg, ws_seen_reg;
  logic                ws_change, slot_start, write_en, load;

  // A WS change only counts once a first WS sample exists, so a reset never fakes a slot start.
  assign ws_change  = sck_rise && ws_seen_reg && (ws_level != ws_cur_reg);
  assign slot_start = ws_change && (ws_level == lr);

  assign sample_ready = !buf_full_reg;
  assign write_en     = sample_valid && !buf_full_reg;

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    buf_next       = buf_reg;
    buf_full_next  = buf_full_reg;
    sd_next        = sd_reg;
    oe_next        = oe_reg;
    underrun_next  = 1'b0;
    frame_err_next = 1'b0;
    load           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (slot_start) begin
          state_next = ARMED;
        end
      end
      ARMED, SHIFT: begin
        if (ws_change) begin
          frame_err_next = 1'b1;
          sd_next        = 1'b0;
          oe_next        = 1'b0;
          bit_cnt_next   = '0;
          state_next     = slot_start ? ARMED : IDLE;
        end else if (sck_fall) begin
          if (state_reg == ARMED) begin
            // An empty buffer sends a zero word rather than stale data.
            load          = 1'b1;
            underrun_next = !buf_full_reg;
            shift_next    = buf_full_reg ? (buf_reg << 1) : '0;
            sd_next       = buf_full_reg & buf_reg[w_sample-1];
            oe_next       = 1'b1;
            bit_cnt_next  = cnt_w'(1);
            state_next    = SHIFT;
          end else if (bit_cnt_reg == cnt_w'(w_sample)) begin
            sd_next      = 1'b0;
            oe_next      = 1'b0;
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            sd_next      = shift_reg[w_sample-1];
            shift_next   = shift_reg << 1;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A load in the same clk as a write sees the old (empty) buffer; the write then fills it.
    if (load) begin
      buf_full_next = 1'b0;
    end
    if (write_en) begin
      buf_next      = sample;
      buf_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      buf_reg       <= '0;
      buf_full_reg  <= 1'b0;
      sd_reg        <= 1'b0;
      oe_reg        <= 1'b0;
      underrun_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      ws_cur_reg    <= 1'b0;
      ws_seen_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      buf_reg       <= buf_next;
      buf_full_reg  <= buf_full_next;
      sd_reg        <= sd_next;
      oe_reg        <= oe_next;
      underrun_reg  <= underrun_next;
      frame_err_reg <= frame_err_next;
      if (sck_rise) begin
        ws_cur_reg  <= ws_level;
        ws_seen_reg <= 1'b1;
      end
    end
  end

  assign sd        = sd_reg;
  assign sd_oe     = oe_reg;
  assign underrun  = underrun_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_inmp441_mic_i2s_transmitter.sv
// Bench acting as I2S master and sample source; a slot-level model predicts sd/sd_oe at every SCK rise.
module tb_inmp441_mic_i2s_transmitter;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          lr;
  logic          sck;
  logic          ws;
  logic          sd;
  logic          sd_oe;
  logic          underrun;
  logic          frame_err;

  inmp441_mic_i2s_transmitter dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .lr(lr), .sck(sck), .ws(ws),
    .sd(sd), .sd_oe(sd_oe), .underrun(underrun), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: samples the DUT must still send, and the slot being transmitted.
  logic [W-1:0] model_q[$];
  logic [W-1:0] up_q[$];
  logic [W-1:0] slot_word;
  int           slot_j;
  bit           slot_live;
  bit           have_prev;
  logic         prev_ws;
  int           exp_und = 0, exp_ferr = 0, obs_und = 0, obs_ferr = 0;
  int           acc_cyc[$];
  int           load_fall_cyc;
  int           g_push_k = -1, g_rst_k = -1, g_chk_k = -1;
  logic [W-1:0] g_push_val;
  logic [W-1:0] last_word;
  int           last_oe;
  int           und0, ferr0;

  always @(negedge clk) begin
    if (underrun === 1'b1) obs_und++;
    if (frame_err === 1'b1) obs_ferr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // At each SCK rise: an lr slot shows bit j of its word at the j-th rise after the start, j=1..24.
  task automatic rise_check(input logic w);
    logic e_oe, e_sd;
    e_oe = 1'b0;
    e_sd = 1'b0;
    if (slot_live) begin
      slot_j++;
      if (slot_j <= W) begin
        e_oe = 1'b1;
        e_sd = slot_word[W - slot_j];
      end
    end
    check("sd_oe_at_rise", sd_oe, e_oe);
    check("sd_at_rise", sd, e_sd);
    check("ready_at_rise", sample_ready, model_q.size() == 0);
    if (have_prev && w != prev_ws) begin
      if (slot_live && slot_j < W) exp_ferr++;
      slot_live = (w == lr);
      if (slot_live) begin
        slot_j = 0;
        if (model_q.size() > 0) slot_word = model_q.pop_front();
        else begin
          slot_word = '0;
          exp_und++;
        end
      end
    end
    prev_ws   = w;
    have_prev = 1'b1;
  endtask

  task automatic push(input logic [W-1:0] v);
    up_q.push_back(v);
    model_q.push_back(v);
  endtask

  task automatic half_frame(input logic w, input int nbits);
    logic [W-1:0] cap;
    int oe_cnt;
    cap = '0;
    oe_cnt = 0;
    for (int k = 0; k < nbits; k++) begin
      sck = 1'b0;
      if (k == 0) ws = w;
      if (w == lr && k == 1) load_fall_cyc = cyc;
      repeat (8) @(posedge clk);
      #1;
      sck = 1'b1;
      if (sd_oe === 1'b1) begin
        cap = {cap[W-2:0], sd};
        oe_cnt++;
      end
      rise_check(w);
      if (k == g_chk_k) begin
        repeat (4) @(posedge clk);
        #1;
        check("sd_oe_off_after_ws_err", sd_oe, 0);
      end
      if (k == g_push_k) push(g_push_val);
      if (k == g_rst_k) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("sd_oe_after_rst", sd_oe, 0);
        check("sd_after_rst", sd, 0);
        check("ready_after_rst", sample_ready, 1);
        model_q.delete();
        slot_live = 1'b0;
        have_prev = 1'b0;
      end
      repeat (8) @(posedge clk);
      #1;
    end
    last_word = cap;
    last_oe   = oe_cnt;
    $display("half ws=%0d lr=%0d periods=%0d oe_bits=%0d word=0x%06h und=%0d ferr=%0d",
             w, lr, nbits, oe_cnt, cap, obs_und, obs_ferr);
  endtask

  // Upstream source: holds valid until a valid&&ready edge, then offers the next queued sample.
  initial begin
    bit take;
    sample_valid = 1'b0;
    sample = '0;
    forever begin
      @(negedge clk);
      take = sample_valid && sample_ready && !rst;
      @(posedge clk);
      #1;
      if (take) begin
        sample_valid = 1'b0;
        acc_cyc.push_back(cyc);
        $display("push accepted 0x%06h at cycle %0d", sample, cyc);
      end
      if (!sample_valid && up_q.size() > 0) begin
        sample = up_q.pop_front();
        sample_valid = 1'b1;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sck = 1'b0; ws = 1'b1; lr = 1'b0;
    slot_live = 1'b0; have_prev = 1'b0; prev_ws = 1'b0; slot_j = 0; slot_word = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sd", sd, 0);
    check("rst_sd_oe", sd_oe, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_ready", sample_ready, 1);
    rst = 1'b0;

    // 1: left slot carries A55AC3, right slot silent.
    push(24'hA55AC3);
    half_frame(1'b1, 32);
    half_frame(1'b0, 32);
    check("t1_word", last_word, 24'hA55AC3);
    check("t1_oe_bits", last_oe, 24);
    half_frame(1'b1, 32);
    check("t1_right_oe_bits", last_oe, 0);
    check("t1_underrun_none", obs_und, 0);

    // 2: right slot carries 800001.
    lr = 1'b1;
    push(24'h800001);
    half_frame(1'b0, 32);
    check("t2_left_oe_bits", last_oe, 0);
    half_frame(1'b1, 32);
    check("t2_word", last_word, 24'h800001);
    check("t2_oe_bits", last_oe, 24);
    check("t2_no_frame_err", obs_ferr, 0);

    // 3: three frames with nothing buffered.
    und0 = obs_und;
    for (int f = 0; f < 3; f++) begin
      half_frame(1'b0, 32);
      half_frame(1'b1, 32);
      check("t3_zero_word", last_word, 0);
      check("t3_oe_bits", last_oe, 24);
    end
    check("t3_underruns", obs_und - und0, 3);

    // 4: back-to-back samples; the second waits for the first slot load.
    push(24'h111111);
    push(24'h222222);
    half_frame(1'b0, 32);
    half_frame(1'b1, 32);
    check("t4_word1", last_word, 24'h111111);
    check("t4_second_accept_cycle", acc_cyc[$], load_fall_cyc + 4);
    half_frame(1'b0, 32);
    half_frame(1'b1, 32);
    check("t4_word2", last_word, 24'h222222);

    // 5: WS toggles after 10 bits; a sample pushed mid-slot is sent in the next full slot.
    ferr0 = obs_ferr;
    push(24'h5A5A5A);
    half_frame(1'b0, 32);
    g_push_k = 3; g_push_val = 24'h0F0F0F;
    half_frame(1'b1, 11);
    g_push_k = -1;
    check("t5_partial_word", last_word, 24'h000169);
    check("t5_partial_bits", last_oe, 10);
    g_chk_k = 0;
    half_frame(1'b0, 32);
    g_chk_k = -1;
    check("t5_frame_err_pulses", obs_ferr - ferr0, 1);
    half_frame(1'b1, 32);
    check("t5_word", last_word, 24'h0F0F0F);

    // 6: reset at bit 12 drops the slot and the buffered sample.
    push(24'h123456);
    half_frame(1'b0, 32);
    g_push_k = 5; g_push_val = 24'h654321; g_rst_k = 12;
    half_frame(1'b1, 32);
    g_push_k = -1; g_rst_k = -1;
    check("t6_partial_word", last_word, 24'h000123);
    check("t6_partial_bits", last_oe, 12);
    und0 = obs_und;
    half_frame(1'b0, 32);
    half_frame(1'b1, 32);
    check("t6_zero_word", last_word, 0);
    check("t6_underrun", obs_und - und0, 1);

    check("underrun_total", obs_und, exp_und);
    check("frame_err_total", obs_ferr, exp_ferr);
    check("source_drained", up_q.size() + sample_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
